// File: rtl/rs_dsp_pkg.sv
// Shared constants and helpers for the rs_dsp_mac_gen2 multiply/accumulate block.
package rs_dsp_pkg;

  localparam int unsigned MODE_MULT = 0;
  localparam int unsigned MODE_MAC  = 1;

  // Saturation limits are carried at a fixed wide width so any OUT_WIDTH <= ACC_WIDTH fits.
  localparam int unsigned LimW = 128;

  typedef struct packed {
    logic signed [LimW-1:0] max_v;
    logic signed [LimW-1:0] min_v;
  } sat_lim_t;

  function automatic int unsigned latency(input int unsigned input_reg,
                                          input int unsigned output_reg);
    return input_reg + 1 + output_reg;
  endfunction

  function automatic sat_lim_t sat_limits(input int unsigned out_width);
    sat_lim_t        lim;
    logic [LimW-1:0] half;
    half      = LimW'(1) << (out_width - 1);
    lim.max_v = $signed(half - LimW'(1));
    lim.min_v = ~lim.max_v;
    return lim;
  endfunction

endpackage

// File: rtl/rs_dsp_mac_gen2_if.sv
// Beat/result bundle for rs_dsp_mac_gen2; OVERFLOW exists only with RS_DSP_MAC_OVERFLOW_FLAG_EN.
interface rs_dsp_mac_gen2_if #(
  parameter int unsigned A_WIDTH   = 20,
  parameter int unsigned B_WIDTH   = 18,
  parameter int unsigned OUT_WIDTH = 38
);
  logic                 VALID_IN;
  logic [A_WIDTH-1:0]   A;
  logic [B_WIDTH-1:0]   B;
  logic                 USE_COEFF;
  logic [2:0]           COEFF_SEL;
  logic                 UNSIGNED_A;
  logic                 UNSIGNED_B;
  logic                 LOAD_ACC;
  logic                 SUBTRACT;
  logic [5:0]           SHIFT_RIGHT;
  logic                 ROUND;
  logic                 SATURATE_ENABLE;
  logic [OUT_WIDTH-1:0] Z;
  logic                 VALID_OUT;
  logic [B_WIDTH-1:0]   DLY_B;
`ifdef RS_DSP_MAC_OVERFLOW_FLAG_EN
  logic                 OVERFLOW;

  modport master (
    output VALID_IN, A, B, USE_COEFF, COEFF_SEL, UNSIGNED_A, UNSIGNED_B, LOAD_ACC, SUBTRACT,
           SHIFT_RIGHT, ROUND, SATURATE_ENABLE,
    input  Z, VALID_OUT, DLY_B, OVERFLOW
  );
  modport slave (
    input  VALID_IN, A, B, USE_COEFF, COEFF_SEL, UNSIGNED_A, UNSIGNED_B, LOAD_ACC, SUBTRACT,
           SHIFT_RIGHT, ROUND, SATURATE_ENABLE,
    output Z, VALID_OUT, DLY_B, OVERFLOW
  );
`else
  modport master (
    output VALID_IN, A, B, USE_COEFF, COEFF_SEL, UNSIGNED_A, UNSIGNED_B, LOAD_ACC, SUBTRACT,
           SHIFT_RIGHT, ROUND, SATURATE_ENABLE,
    input  Z, VALID_OUT, DLY_B
  );
  modport slave (
    input  VALID_IN, A, B, USE_COEFF, COEFF_SEL, UNSIGNED_A, UNSIGNED_B, LOAD_ACC, SUBTRACT,
           SHIFT_RIGHT, ROUND, SATURATE_ENABLE,
    output Z, VALID_OUT, DLY_B
  );
`endif
endinterface

// File: rtl/rs_dsp_round_sat.sv
// Combinational output transform: optional round half-up, arithmetic shift right, then
// saturate or truncate to OUT_WIDTH. clamped_o flags a saturation event.
module rs_dsp_round_sat
  import rs_dsp_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 48,
  parameter int unsigned OUT_WIDTH = 38
) (
  input  logic [ACC_WIDTH-1:0] r_i,
  input  logic [5:0]           shift_right_i,
  input  logic                 round_i,
  input  logic                 saturate_enable_i,
  output logic [OUT_WIDTH-1:0] z_o,
  output logic                 clamped_o
);
  localparam int unsigned WideW = ACC_WIDTH + 1;
  localparam sat_lim_t Lim = sat_limits(OUT_WIDTH);
  localparam logic signed [LimW-1:0] MaxV = Lim.max_v;
  localparam logic signed [LimW-1:0] MinV = Lim.min_v;

  logic [5:0]              s;
  logic signed [WideW-1:0] rnd, rounded, shifted;
  logic signed [LimW-1:0]  wide;

  always_comb begin
    s = shift_right_i;
    if (32'(shift_right_i) > ACC_WIDTH - 1) s = 6'(ACC_WIDTH - 1);
    rnd = '0;
    if (round_i && s != 6'd0) rnd = WideW'(1) << (s - 6'd1);
    // One extra bit keeps the rounding add from wrapping at the positive limit.
    rounded   = $signed({r_i[ACC_WIDTH-1], r_i}) + rnd;
    shifted   = rounded >>> s;
    wide      = LimW'(shifted);
    z_o       = shifted[OUT_WIDTH-1:0];
    clamped_o = 1'b0;
    if (saturate_enable_i) begin
      if (wide > MaxV) begin
        z_o       = MaxV[OUT_WIDTH-1:0];
        clamped_o = 1'b1;
      end else if (wide < MinV) begin
        z_o       = MinV[OUT_WIDTH-1:0];
        clamped_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_dsp_mac_gen2.sv
// Parametrised multiply / multiply-accumulate DSP block with valid-qualified pipeline.
// Optional sticky OVERFLOW output under RS_DSP_MAC_OVERFLOW_FLAG_EN.
module rs_dsp_mac_gen2
  import rs_dsp_pkg::*;
#(
  parameter int unsigned A_WIDTH    = 20,
  parameter int unsigned B_WIDTH    = 18,
  parameter int unsigned ACC_WIDTH  = 48,
  parameter int unsigned OUT_WIDTH  = 38,
  parameter int unsigned NUM_COEFF  = 4,
  parameter logic [NUM_COEFF*A_WIDTH-1:0] COEFFS = '0,
  parameter int unsigned MODE       = MODE_MULT,
  parameter int unsigned INPUT_REG  = 0,
  parameter int unsigned OUTPUT_REG = 0
) (
  input logic              CLK,
  input logic              LRESET,
  rs_dsp_mac_gen2_if.slave bus
);
  localparam int unsigned PW = A_WIDTH + B_WIDTH + 2;
  localparam int unsigned WW = (PW > ACC_WIDTH) ? PW : ACC_WIDTH;

  typedef struct packed {
    logic               valid;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic               use_coeff;
    logic [2:0]         coeff_sel;
    logic               unsigned_a;
    logic               unsigned_b;
    logic               load_acc;
    logic               subtract;
    logic [5:0]         shift_right;
    logic               round;
    logic               sat_en;
  } beat_t;

  beat_t beat_raw, beat;

  always_comb begin
    beat_raw.valid       = bus.VALID_IN;
    beat_raw.a           = bus.A;
    beat_raw.b           = bus.B;
    beat_raw.use_coeff   = bus.USE_COEFF;
    beat_raw.coeff_sel   = bus.COEFF_SEL;
    beat_raw.unsigned_a  = bus.UNSIGNED_A;
    beat_raw.unsigned_b  = bus.UNSIGNED_B;
    beat_raw.load_acc    = bus.LOAD_ACC;
    beat_raw.subtract    = bus.SUBTRACT;
    beat_raw.shift_right = bus.SHIFT_RIGHT;
    beat_raw.round       = bus.ROUND;
    beat_raw.sat_en      = bus.SATURATE_ENABLE;
  end

  if (INPUT_REG != 0) begin : g_in_reg
    beat_t beat_q;
    always_ff @(posedge CLK) begin
      if (LRESET) beat_q <= '0;
      else        beat_q <= beat_raw;
    end
    assign beat = beat_q;
  end else begin : g_in_comb
    assign beat = beat_raw;
  end

  logic [2:0]           sel_eff;
  logic [A_WIDTH-1:0]   m;
  logic signed [WW-1:0] m_ext, b_ext, prod;
  logic [ACC_WIDTH-1:0] p, p_n, sum, r_d;
  logic [ACC_WIDTH-1:0] r_q;
  logic [B_WIDTH-1:0]   dly_b_q;
  logic                 acc_valid_q;
  logic [5:0]           shift_q;
  logic                 round_q, sat_q;

  always_comb begin
    sel_eff = (32'(beat.coeff_sel) < NUM_COEFF) ? beat.coeff_sel : 3'd0;
    m       = beat.use_coeff ? COEFFS[32'(sel_eff) * A_WIDTH +: A_WIDTH] : beat.a;
    m_ext   = beat.unsigned_a ? $signed(WW'(m)) : WW'($signed(m));
    b_ext   = beat.unsigned_b ? $signed(WW'(beat.b)) : WW'($signed(beat.b));
    // Operands are pre-extended so the WW-bit product is exact.
    prod    = m_ext * b_ext;
    p       = prod[ACC_WIDTH-1:0];
    p_n     = beat.subtract ? -p : p;
    sum     = r_q + p_n;
    r_d     = (MODE == MODE_MAC && !beat.load_acc) ? sum : p_n;
  end

  always_ff @(posedge CLK) begin
    if (LRESET) begin
      r_q         <= '0;
      dly_b_q     <= '0;
      acc_valid_q <= 1'b0;
      shift_q     <= '0;
      round_q     <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      acc_valid_q <= beat.valid;
      if (beat.valid) begin
        r_q     <= r_d;
        dly_b_q <= beat.b;
        shift_q <= beat.shift_right;
        round_q <= beat.round;
        sat_q   <= beat.sat_en;
      end
    end
  end

  logic [OUT_WIDTH-1:0] z_rs;
  logic                 clamped;

  rs_dsp_round_sat #(
    .ACC_WIDTH(ACC_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_round_sat (
    .r_i              (r_q),
    .shift_right_i    (shift_q),
    .round_i          (round_q),
    .saturate_enable_i(sat_q),
    .z_o              (z_rs),
    .clamped_o        (clamped)
  );

`ifdef RS_DSP_MAC_OVERFLOW_FLAG_EN
  logic wrap, wrap_sticky_q, sat_hist_q, ovf_cur;

  assign wrap = (MODE == MODE_MAC) && !beat.load_acc &&
                (r_q[ACC_WIDTH-1] == p_n[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != r_q[ACC_WIDTH-1]);

  // sat_hist_q holds clamps of earlier beats since the last load; the beat now in R
  // contributes its clamp combinationally.
  always_ff @(posedge CLK) begin
    if (LRESET) begin
      wrap_sticky_q <= 1'b0;
      sat_hist_q    <= 1'b0;
    end else if (beat.valid) begin
      wrap_sticky_q <= beat.load_acc ? 1'b0 : (wrap_sticky_q | wrap);
      sat_hist_q    <= beat.load_acc ? 1'b0 : (sat_hist_q | clamped);
    end
  end

  assign ovf_cur = wrap_sticky_q | sat_hist_q | clamped;
`else
  logic unused_clamped;
  assign unused_clamped = clamped;
`endif

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [OUT_WIDTH-1:0] z_q;
    logic                 vout_q;
`ifdef RS_DSP_MAC_OVERFLOW_FLAG_EN
    logic                 ovf_q;
`endif
    always_ff @(posedge CLK) begin
      if (LRESET) begin
        z_q    <= '0;
        vout_q <= 1'b0;
`ifdef RS_DSP_MAC_OVERFLOW_FLAG_EN
        ovf_q  <= 1'b0;
`endif
      end else begin
        vout_q <= acc_valid_q;
        if (acc_valid_q) begin
          z_q   <= z_rs;
`ifdef RS_DSP_MAC_OVERFLOW_FLAG_EN
          ovf_q <= ovf_cur;
`endif
        end
      end
    end
    assign bus.Z         = z_q;
    assign bus.VALID_OUT = vout_q;
`ifdef RS_DSP_MAC_OVERFLOW_FLAG_EN
    assign bus.OVERFLOW  = ovf_q;
`endif
  end else begin : g_out_comb
    assign bus.Z         = z_rs;
    assign bus.VALID_OUT = acc_valid_q;
`ifdef RS_DSP_MAC_OVERFLOW_FLAG_EN
    assign bus.OVERFLOW  = ovf_cur;
`endif
  end

  assign bus.DLY_B = dly_b_q;

endmodule
